// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding, parameter
// defaults and the MEM/WB register bundle.
package mem_stage_pkg;

    localparam logic [31:0] ADDR_BASE_DEFAULT = 32'd1024;
    localparam int          MEM_AW_DEFAULT    = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic        wb_en;
        logic        mem_r_en;
        logic [31:0] alu_result;
        logic [31:0] mem_data;
        logic [3:0]  dest;
    } mem_wb_t;

    // Snapshot of the EXE result taken when a memory op is accepted.
    typedef struct packed {
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic [31:0] alu_result;
        logic [31:0] st_val;
        logic [3:0]  dest;
    } hold_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and
// the data memory (slave).
interface mem_stage_if
    import mem_stage_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEFAULT
);
    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: synchronous reset and clear (bubble) take
// priority over load.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    clr,
    input  logic    ld,
    input  mem_wb_t d,
    output mem_wb_t q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: ALU results pass in one cycle, loads/stores stall
// upstream until the data memory acks. Optional MEM_STAGE_ALIGN_CHK_EN adds align_err.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEFAULT,
    parameter int          MEM_AW    = MEM_AW_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_valid,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] st_val_in,
    input  logic [3:0]  dest_in,
    output logic        stall,
    mem_stage_if.master dmem,
    output logic        wb_en_out,
    output logic        mem_r_en_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] mem_data_out,
    output logic [3:0]  dest_out
`ifdef MEM_STAGE_ALIGN_CHK_EN
    ,
    output logic        align_err
`endif
);

    state_t  state_q, state_d;
    hold_t   hold_q;
    logic    hold_ld;
    logic    wb_ld;
    logic    mem_op;
    logic    misaligned;
    mem_wb_t wb_d, wb_q;

    assign mem_op = mem_r_en_in | mem_w_en_in;

`ifdef MEM_STAGE_ALIGN_CHK_EN
    assign misaligned = |alu_result_in[1:0];
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        hold_ld = 1'b0;
        wb_ld   = 1'b0;
        wb_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (exe_valid && mem_op && !misaligned) begin
                    stall   = 1'b1;
                    hold_ld = 1'b1;
                    state_d = ACCESS;
                end else if (exe_valid) begin
                    // A misaligned access retires here as a non-writing op.
                    wb_ld           = 1'b1;
                    wb_d.wb_en      = wb_en_in & ~mem_op;
                    wb_d.alu_result = alu_result_in;
                    wb_d.dest       = dest_in;
                end
            end
            ACCESS: begin
                if (dmem.mem_ack) begin
                    state_d         = IDLE;
                    wb_ld           = 1'b1;
                    wb_d.wb_en      = hold_q.wb_en;
                    wb_d.mem_r_en   = hold_q.mem_r_en;
                    wb_d.alu_result = hold_q.alu_result;
                    wb_d.mem_data   = hold_q.mem_r_en ? dmem.mem_rdata : 32'h0;
                    wb_d.dest       = hold_q.dest;
                end else begin
                    stall = 1'b1;
                end
            end
        endcase
        if (rst) begin
            stall = 1'b0;
        end
    end

    // A combined read+write request is performed as a write only.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (hold_ld) begin
            hold_q.wb_en      <= wb_en_in;
            hold_q.mem_r_en   <= mem_r_en_in & ~mem_w_en_in;
            hold_q.mem_w_en   <= mem_w_en_in;
            hold_q.alu_result <= alu_result_in;
            hold_q.st_val     <= st_val_in;
            hold_q.dest       <= dest_in;
        end
    end

    assign dmem.mem_req   = (state_q == ACCESS);
    assign dmem.mem_we    = (state_q == ACCESS) && hold_q.mem_w_en;
    assign dmem.mem_addr  = MEM_AW'((hold_q.alu_result - ADDR_BASE) >> 2);
    assign dmem.mem_wdata = hold_q.st_val;

`ifdef MEM_STAGE_ALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            align_err <= 1'b0;
        end else begin
            align_err <= (state_q == IDLE) && exe_valid && mem_op && misaligned;
        end
    end
`endif

    mem_wb_reg u_mem_wb_reg (
        .clk (clk),
        .rst (rst),
        .clr (~wb_ld),
        .ld  (wb_ld),
        .d   (wb_d),
        .q   (wb_q)
    );

    assign wb_en_out      = wb_q.wb_en;
    assign mem_r_en_out   = wb_q.mem_r_en;
    assign alu_result_out = wb_q.alu_result;
    assign mem_data_out   = wb_q.mem_data;
    assign dest_out       = wb_q.dest;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: reset, a vector table of single-cycle
// ops, directed multi-cycle load/store/reset sequences and a random stream.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int AW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_valid;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic [31:0] alu_result_in;
    logic [31:0] st_val_in;
    logic [3:0]  dest_in;
    logic        stall;
    logic        wb_en_out;
    logic        mem_r_en_out;
    logic [31:0] alu_result_out;
    logic [31:0] mem_data_out;
    logic [3:0]  dest_out;
`ifdef MEM_STAGE_ALIGN_CHK_EN
    logic        align_err;
`endif

    always #5 clk = ~clk;

    mem_stage_if #(.MEM_AW(AW)) dmem ();

    mem_stage #(.ADDR_BASE(32'd1024), .MEM_AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .exe_valid      (exe_valid),
        .wb_en_in       (wb_en_in),
        .mem_r_en_in    (mem_r_en_in),
        .mem_w_en_in    (mem_w_en_in),
        .alu_result_in  (alu_result_in),
        .st_val_in      (st_val_in),
        .dest_in        (dest_in),
        .stall          (stall),
        .dmem           (dmem),
        .wb_en_out      (wb_en_out),
        .mem_r_en_out   (mem_r_en_out),
        .alu_result_out (alu_result_out),
        .mem_data_out   (mem_data_out),
        .dest_out       (dest_out)
`ifdef MEM_STAGE_ALIGN_CHK_EN
        ,
        .align_err      (align_err)
`endif
    );

    typedef struct {
        bit          valid, wb, r, w;
        logic [31:0] alu, st;
        logic [3:0]  dest;
    } instr_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [31:0]   wdata;
    } tx_t;

    typedef struct {
        instr_t      in;
        bit          ack;
        bit          exp_wb, exp_r, chk;
        logic [31:0] exp_alu;
        logic [3:0]  exp_dest;
    } vec_t;

    int  total = 0;
    int  bad   = 0;
    int  last_stall_cnt;
    tx_t txq[$];
    tx_t exp_txq[$];

    // Every completed memory transaction as seen on the bus.
    always @(posedge clk) begin
        if (dmem.mem_req && dmem.mem_ack) begin
            txq.push_back({dmem.mem_addr, dmem.mem_we, dmem.mem_we ? dmem.mem_wdata : 32'h0});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input instr_t i);
        exe_valid     = i.valid;
        wb_en_in      = i.wb;
        mem_r_en_in   = i.r;
        mem_w_en_in   = i.w;
        alu_result_in = i.alu;
        st_val_in     = i.st;
        dest_in       = i.dest;
    endtask

    task automatic drive_idle();
        instr_t i;
        i = '{0, 0, 0, 0, 32'h0, 32'h0, 4'h0};
        drive(i);
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid = 1'($urandom_range(0, 1));
        i.wb    = 1'($urandom_range(0, 1));
        i.r     = 1'($urandom_range(0, 1));
        i.w     = 1'($urandom_range(0, 1));
        i.alu   = $urandom();
        i.st    = $urandom();
        i.dest  = 4'($urandom_range(0, 15));
        return i;
    endfunction

    // Word address seen by memory: (byte address - 1024) mod 2^32, divided by 4.
    function automatic logic [AW-1:0] exp_addr(input logic [31:0] byte_addr);
        logic [31:0] off;
        off = byte_addr - 32'd1024;
        return off[AW+1:2];
    endfunction

    // What MEM/WB must hold once instruction i retires (rd = memory read data).
    task automatic check_out(input string name, input instr_t i, input logic [31:0] rd);
        bit ld_only;
        ld_only = i.r && !i.w;
        check({name, " wb_en_out"}, 32'(wb_en_out), 32'(i.valid && i.wb));
        check({name, " mem_r_en_out"}, 32'(mem_r_en_out), 32'(i.valid && ld_only));
        if (i.valid) begin
            check({name, " alu_result_out"}, alu_result_out, i.alu);
            check({name, " dest_out"}, 32'(dest_out), 32'(i.dest));
            check({name, " mem_data_out"}, mem_data_out, ld_only ? rd : 32'h0);
        end
    endtask

    // Single-cycle op (ALU or bubble); ack pulses while idle must be ignored.
    task automatic alu_op(input instr_t i, input bit ack, input string name);
        drive(i);
        dmem.mem_ack = ack;
        #1;
        check({name, " stall"}, 32'(stall), 32'h0);
        check({name, " mem_req"}, 32'(dmem.mem_req), 32'h0);
        tick();
        dmem.mem_ack = 1'b0;
        check_out(name, i, 32'h0);
    endtask

    // Load/store with ack in ACCESS cycle 'lat'; optional upstream noise during ACCESS.
    task automatic mem_op(input instr_t i, input int lat, input logic [31:0] rd,
                          input bit scramble, input string name);
        tx_t t;
        t.addr  = exp_addr(i.alu);
        t.we    = i.w;
        t.wdata = i.w ? i.st : 32'h0;
        exp_txq.push_back(t);
        last_stall_cnt = 0;
        drive(i);
        for (int c = 0; c <= lat; c++) begin
            if (scramble && c > 0) drive(rand_instr());
            dmem.mem_ack   = (c == lat);
            dmem.mem_rdata = (c == lat) ? rd : $urandom();
            #1;
            if (stall) last_stall_cnt++;
            check($sformatf("%s c%0d stall", name, c), 32'(stall), 32'(c < lat));
            check($sformatf("%s c%0d mem_req", name, c), 32'(dmem.mem_req), 32'(c > 0));
            if (c > 0) begin
                check($sformatf("%s c%0d mem_we", name, c), 32'(dmem.mem_we), 32'(i.w));
                check($sformatf("%s c%0d mem_addr", name, c), 32'(dmem.mem_addr), 32'(t.addr));
                if (i.w) check($sformatf("%s c%0d mem_wdata", name, c), dmem.mem_wdata, i.st);
            end
            tick();
            dmem.mem_ack = 1'b0;
            if (c < lat) begin
                check($sformatf("%s c%0d bubble wb_en", name, c), 32'(wb_en_out), 32'h0);
                check($sformatf("%s c%0d bubble r_en", name, c), 32'(mem_r_en_out), 32'h0);
            end else begin
                check_out(name, i, rd);
            end
        end
    endtask

    task automatic cmp_tx(input string name);
        check({name, " tx count"}, txq.size(), exp_txq.size());
        for (int k = 0; k < txq.size() && k < exp_txq.size(); k++) begin
            check($sformatf("%s tx%0d addr", name, k), 32'(txq[k].addr), 32'(exp_txq[k].addr));
            check($sformatf("%s tx%0d we", name, k), 32'(txq[k].we), 32'(exp_txq[k].we));
            check($sformatf("%s tx%0d wdata", name, k), txq[k].wdata, exp_txq[k].wdata);
        end
        txq.delete();
        exp_txq.delete();
    endtask

    vec_t   vecs[7];
    instr_t ri;
    int     kind;

    initial begin
        vecs[0] = '{'{1, 1, 0, 0, 32'h55,       32'h0,    4'd3},  0, 1, 0, 1, 32'h55,       4'd3};
        vecs[1] = '{'{0, 1, 0, 0, 32'h77,       32'h0,    4'd5},  0, 0, 0, 0, 32'h0,        4'd0};
        vecs[2] = '{'{1, 0, 0, 0, 32'hFFFFFFFF, 32'h0,    4'd15}, 1, 0, 0, 1, 32'hFFFFFFFF, 4'd15};
        vecs[3] = '{'{1, 1, 0, 0, 32'h0,        32'h0,    4'd0},  1, 1, 0, 1, 32'h0,        4'd0};
        vecs[4] = '{'{1, 1, 0, 0, 32'h80000001, 32'h0,    4'd9},  0, 1, 0, 1, 32'h80000001, 4'd9};
        vecs[5] = '{'{0, 1, 1, 0, 32'h400,      32'h0,    4'd2},  0, 0, 0, 0, 32'h0,        4'd0};
        vecs[6] = '{'{0, 0, 0, 1, 32'h404,      32'hAAAA, 4'd1},  1, 0, 0, 0, 32'h0,        4'd0};

        // Reset, with a load presented: stall must stay low, everything cleared.
        rst            = 1'b1;
        dmem.mem_ack   = 1'b0;
        dmem.mem_rdata = 32'h0;
        ri = '{1, 1, 1, 0, 32'd1032, 32'h0, 4'd7};
        drive(ri);
        tick();
        tick();
        check("reset stall", 32'(stall), 32'h0);
        check("reset mem_req", 32'(dmem.mem_req), 32'h0);
        check("reset wb_en_out", 32'(wb_en_out), 32'h0);
        check("reset mem_r_en_out", 32'(mem_r_en_out), 32'h0);
        check("reset alu_result_out", alu_result_out, 32'h0);
        check("reset mem_data_out", mem_data_out, 32'h0);
        check("reset dest_out", 32'(dest_out), 32'h0);
        drive_idle();
        rst = 1'b0;
        tick();

        // Single-cycle vector table.
        for (int v = 0; v < 7; v++) begin
            drive(vecs[v].in);
            dmem.mem_ack = vecs[v].ack;
            #1;
            check($sformatf("vec%0d stall", v), 32'(stall), 32'h0);
            check($sformatf("vec%0d mem_req", v), 32'(dmem.mem_req), 32'h0);
            tick();
            dmem.mem_ack = 1'b0;
            check($sformatf("vec%0d wb_en_out", v), 32'(wb_en_out), 32'(vecs[v].exp_wb));
            check($sformatf("vec%0d mem_r_en_out", v), 32'(mem_r_en_out), 32'(vecs[v].exp_r));
            if (vecs[v].chk) begin
                check($sformatf("vec%0d alu_result_out", v), alu_result_out, vecs[v].exp_alu);
                check($sformatf("vec%0d dest_out", v), 32'(dest_out), 32'(vecs[v].exp_dest));
                check($sformatf("vec%0d mem_data_out", v), mem_data_out, 32'h0);
            end
        end
        cmp_tx("vectors");

        // Load at 1032, ack in the third ACCESS cycle.
        ri = '{1, 1, 1, 0, 32'd1032, 32'h0, 4'd7};
        mem_op(ri, 3, 32'hDEADBEEF, 1'b0, "load1032");
        check("load1032 stall cycles", last_stall_cnt, 3);
        check("load1032 word addr", 32'(exp_txq[0].addr), 32'd2);
        // Store at 1024, ack in the first ACCESS cycle.
        ri = '{1, 0, 0, 1, 32'd1024, 32'h1234, 4'd1};
        mem_op(ri, 1, 32'hFFFFFFFF, 1'b0, "store1024");
        check("store1024 stall cycles", last_stall_cnt, 1);
        drive_idle();
        cmp_tx("directed");

        // Back-to-back load, store, load+store with upstream noise during ACCESS.
        ri = '{1, 1, 1, 0, 32'd1044, 32'h0, 4'd8};
        mem_op(ri, 2, 32'h600DF00D, 1'b1, "b2b load");
        ri = '{1, 0, 0, 1, 32'd5120, 32'hCAFEF00D, 4'd9};
        mem_op(ri, 3, 32'h11111111, 1'b1, "b2b store");
        ri = '{1, 1, 1, 1, 32'd1028, 32'h0BADF00D, 4'd10};
        mem_op(ri, 1, 32'h22222222, 1'b1, "b2b rw");
        drive_idle();
        cmp_tx("back-to-back");

        // Reset in the second ACCESS cycle; the late ack must be ignored.
        ri = '{1, 1, 1, 0, 32'd1040, 32'h0, 4'd4};
        drive(ri);
        tick();
        #1;
        check("rst-access req cycle1", 32'(dmem.mem_req), 32'h1);
        tick();
        rst = 1'b1;
        #1;
        check("rst-access stall under rst", 32'(stall), 32'h0);
        tick();
        rst = 1'b0;
        drive_idle();
        dmem.mem_ack   = 1'b1;
        dmem.mem_rdata = 32'hBAD0BAD0;
        #1;
        check("rst-access mem_req after rst", 32'(dmem.mem_req), 32'h0);
        check("rst-access stall after rst", 32'(stall), 32'h0);
        check("rst-access wb_en_out", 32'(wb_en_out), 32'h0);
        check("rst-access alu_result_out", alu_result_out, 32'h0);
        check("rst-access dest_out", 32'(dest_out), 32'h0);
        tick();
        dmem.mem_ack = 1'b0;
        check("rst-access late ack wb_en_out", 32'(wb_en_out), 32'h0);
        check("rst-access late ack r_en_out", 32'(mem_r_en_out), 32'h0);
        check("rst-access late ack mem_data", mem_data_out, 32'h0);
        ri = '{1, 1, 0, 0, 32'h99, 32'h0, 4'd6};
        alu_op(ri, 1'b0, "post-reset alu");
        cmp_tx("reset-abort");

`ifdef MEM_STAGE_ALIGN_CHK_EN
        // Misaligned load retires in one cycle without a memory request.
        ri = '{1, 1, 1, 0, 32'd1025, 32'h0, 4'd5};
        drive(ri);
        #1;
        check("misaligned stall", 32'(stall), 32'h0);
        check("misaligned mem_req", 32'(dmem.mem_req), 32'h0);
        tick();
        check("misaligned align_err", 32'(align_err), 32'h1);
        check("misaligned wb_en_out", 32'(wb_en_out), 32'h0);
        check("misaligned mem_req next", 32'(dmem.mem_req), 32'h0);
        ri = '{1, 1, 0, 0, 32'h10, 32'h0, 4'd2};
        alu_op(ri, 1'b0, "after misaligned");
        check("after misaligned align_err", 32'(align_err), 32'h0);
        cmp_tx("misaligned");
`endif

        // Random instruction stream with random ack latencies.
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 4);
            ri = rand_instr();
            ri.valid = (kind != 0);
            if (kind == 1) begin
                ri.r = 1'b0;
                ri.w = 1'b0;
            end else if (kind >= 2) begin
                ri.r = (kind == 2) || (kind == 4);
                ri.w = (kind == 3) || (kind == 4);
                if ($urandom_range(0, 3) == 0) ri.alu = $urandom() & ~32'h3;
                else ri.alu = 32'd1024 + 32'(4 * $urandom_range(0, 16383));
            end
            if (ri.valid && (ri.r || ri.w)) begin
                mem_op(ri, $urandom_range(1, 4), $urandom(), 1'($urandom_range(0, 1)),
                       $sformatf("rand%0d mem", n));
            end else begin
                alu_op(ri, 1'($urandom_range(0, 1)), $sformatf("rand%0d alu", n));
            end
        end
        drive_idle();
        tick();
        cmp_tx("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
